// File: rtl/tetris_pkg.sv
// ============================================================================
// Module      : tetris_pkg
// Description : Shared playfield geometry defaults and line-clear FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tetris_pkg;

   localparam int c_mem_width  = 10;
   localparam int c_mem_height = 6;
   localparam int c_width      = 8;

   typedef logic [2:0] state_t;

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_scan   = 3'd1;
   localparam logic [2:0] c_st_shift  = 3'd2;
   localparam logic [2:0] c_st_border = 3'd3;
   localparam logic [2:0] c_st_done   = 3'd4;

   // Bits needed to hold 0..v-1, never less than one.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

`default_nettype wire

// File: rtl/column_height.sv
// ============================================================================
// Module      : column_height
// Description : Index of the topmost occupied cell in one column, or
//               MEM_HEIGHT when the column is empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module column_height
   import tetris_pkg::*;
#(
   parameter int MEM_HEIGHT = c_mem_height,
   parameter int WIDTH      = c_width
) (
   input  logic [MEM_HEIGHT-1:0] i_column,
   output logic [WIDTH-1:0]      o_top
);

   // Descending walk so the smallest occupied row index wins.
   always_comb begin
      o_top = WIDTH'(MEM_HEIGHT);
      for (int j = MEM_HEIGHT - 1; j >= 0; j--) begin
         if (i_column[j])
            o_top = WIDTH'(j);
      end
   end

endmodule

`default_nettype wire

// File: rtl/reset_register.sv
// ============================================================================
// Module      : reset_register
// Description : Enabled register with asynchronous active-high reset value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_register #(
   parameter int           W           = 1,
   parameter logic [W-1:0] RESET_VALUE = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         o_q <= RESET_VALUE;
      else if (i_en)
         o_q <= i_d;
   end

endmodule

`default_nettype wire

// File: rtl/line_clear.sv
// ============================================================================
// Module      : line_clear
// Description : Removes full rows from the playfield bottom-up, compacts the
//               rows above and reports per-column stack heights.
//               Optional LINE_CLEAR_SCORE_EN adds a saturating line total.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_clear
   import tetris_pkg::*;
#(
   parameter int MEM_WIDTH  = c_mem_width,
   parameter int MEM_HEIGHT = c_mem_height,
   parameter int WIDTH      = c_width
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [MEM_WIDTH*MEM_HEIGHT-1:0] field_in,
   output logic                            busy,
   output logic                            done,
   output logic [MEM_WIDTH*MEM_HEIGHT-1:0] field_out,
   output logic [MEM_WIDTH*WIDTH-1:0]      border,
   output logic [WIDTH-1:0]                lines_cleared,
   output logic [15:0]                     total_lines
);

   localparam int c_n     = MEM_WIDTH * MEM_HEIGHT;
   localparam int c_bw    = MEM_WIDTH * WIDTH;
   localparam int c_row_w = clog2_min1(MEM_HEIGHT);
   localparam int c_col_w = clog2_min1(MEM_WIDTH);
   localparam int c_cnt_w = clog2_min1(MEM_HEIGHT + 1);
   localparam logic [c_bw-1:0] c_border_rst = {MEM_WIDTH{WIDTH'(MEM_HEIGHT)}};

   state_t               r_state;
   logic [c_row_w-1:0]   r_row;
   logic [c_col_w-1:0]   r_col;
   logic [c_cnt_w-1:0]   r_count;
   logic [c_bw-1:0]      r_border_work;
   logic [c_n-1:0]       r_field;

   logic                  w_row_full;
   logic [c_n-1:0]        w_shifted;
   logic [MEM_HEIGHT-1:0] w_column;
   logic [WIDTH-1:0]      w_top;
   logic [c_bw-1:0]       w_border_next;
   logic                  w_field_load;
   logic                  w_last;

   // Row j occupies the slice starting at bit c_n-1-MEM_WIDTH*j, column 0 first.
   always_comb begin
      w_row_full = 1'b0;
      w_shifted  = r_field;
      w_column   = '0;
      for (int j = 0; j < MEM_HEIGHT; j++) begin
         if (c_row_w'(j) == r_row)
            w_row_full = &r_field[c_n-1-MEM_WIDTH*j -: MEM_WIDTH];
         if (j == 0)
            w_shifted[c_n-1 -: MEM_WIDTH] = '0;
         else if (c_row_w'(j) <= r_row)
            w_shifted[c_n-1-MEM_WIDTH*j -: MEM_WIDTH] =
               r_field[c_n-1-MEM_WIDTH*(j-1) -: MEM_WIDTH];
         for (int c = 0; c < MEM_WIDTH; c++) begin
            if (c_col_w'(c) == r_col)
               w_column[j] = r_field[c_n-1-MEM_WIDTH*j-c];
         end
      end
   end

   column_height #(
      .MEM_HEIGHT (MEM_HEIGHT),
      .WIDTH      (WIDTH)
   ) u_column_height (
      .i_column (w_column),
      .o_top    (w_top)
   );

   always_comb begin
      w_border_next = r_border_work;
      for (int c = 0; c < MEM_WIDTH; c++) begin
         if (c_col_w'(c) == r_col)
            w_border_next[c_bw-1-WIDTH*c -: WIDTH] = w_top;
      end
   end

   assign w_field_load = ((r_state == c_st_idle) && start) || (r_state == c_st_shift);
   assign w_last       = (r_state == c_st_border) && (r_col == c_col_w'(MEM_WIDTH - 1));
   assign busy         = (r_state == c_st_scan) || (r_state == c_st_shift) ||
                         (r_state == c_st_border);
   assign done         = (r_state == c_st_done);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= c_st_idle;
         r_row         <= '0;
         r_col         <= '0;
         r_count       <= '0;
         r_border_work <= c_border_rst;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (start) begin
                  r_state <= c_st_scan;
                  r_row   <= c_row_w'(MEM_HEIGHT - 1);
                  r_count <= '0;
               end
            end
            c_st_scan: begin
               if (w_row_full) begin
                  r_state <= c_st_shift;
               end else if (r_row == '0) begin
                  r_state <= c_st_border;
                  r_col   <= '0;
               end else begin
                  r_row <= r_row - c_row_w'(1);
               end
            end
            c_st_shift: begin
               // Row index is kept so the row that just dropped in is re-checked.
               r_count <= r_count + c_cnt_w'(1);
               r_state <= c_st_scan;
            end
            c_st_border: begin
               r_border_work <= w_border_next;
               if (w_last)
                  r_state <= c_st_done;
               else
                  r_col <= r_col + c_col_w'(1);
            end
            c_st_done: r_state <= c_st_idle;
            default:   r_state <= c_st_idle;
         endcase
      end
   end

   reset_register #(.W(c_n), .RESET_VALUE('0)) u_field_reg (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_field_load),
      .i_d  ((r_state == c_st_idle) ? field_in : w_shifted),
      .o_q  (r_field)
   );

   // Results are published on the edge entering DONE so they are valid with done.
   reset_register #(.W(c_n), .RESET_VALUE('0)) u_field_out_reg (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_last),
      .i_d  (r_field),
      .o_q  (field_out)
   );

   reset_register #(.W(c_bw), .RESET_VALUE(c_border_rst)) u_border_reg (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_last),
      .i_d  (w_border_next),
      .o_q  (border)
   );

   reset_register #(.W(WIDTH), .RESET_VALUE('0)) u_lines_reg (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_last),
      .i_d  (WIDTH'(r_count)),
      .o_q  (lines_cleared)
   );

`ifdef LINE_CLEAR_SCORE_EN
   logic [16:0] w_sum;

   assign w_sum = {1'b0, total_lines} + 17'(lines_cleared);

   reset_register #(.W(16), .RESET_VALUE('0)) u_total_reg (
      .clk  (clk),
      .rst  (rst),
      .i_en (done),
      .i_d  (w_sum[16] ? 16'hFFFF : w_sum[15:0]),
      .o_q  (total_lines)
   );
`else
   assign total_lines = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_line_clear.sv
// ============================================================================
// Module      : tb_line_clear
// Description : Directed self-checking bench for line_clear at default size.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_clear;

   localparam int c_w = 10;
   localparam int c_h = 6;
   localparam int c_n = 60;

   logic          clk;
   logic          rst;
   logic          start;
   logic [59:0]   field_in;
   logic          busy;
   logic          done;
   logic [59:0]   field_out;
   logic [79:0]   border;
   logic [7:0]    lines_cleared;
   logic [15:0]   total_lines;

   int vectors;
   int miscompares;

   line_clear u_dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .field_in      (field_in),
      .busy          (busy),
      .done          (done),
      .field_out     (field_out),
      .border        (border),
      .lines_cleared (lines_cleared),
      .total_lines   (total_lines)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [127:0] got,
                              input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int bit_of(input int i, input int j);
      return c_n - 1 - (c_w * j + i);
   endfunction

   function automatic logic [59:0] full_row(input int j);
      logic [59:0] f;
      f = '0;
      for (int i = 0; i < c_w; i++) f[bit_of(i, j)] = 1'b1;
      return f;
   endfunction

   function automatic logic [59:0] one_cell(input int i, input int j);
      logic [59:0] f;
      f = '0;
      f[bit_of(i, j)] = 1'b1;
      return f;
   endfunction

   function automatic logic [79:0] border_with(input int col, input int val);
      logic [79:0] b;
      b = {10{8'd6}};
      if (col >= 0) b[79-8*col -: 8] = 8'(val);
      return b;
   endfunction

   // Pulse start on edge 0, optionally re-pulse on edge `repulse`, watch 40 edges.
   task automatic run_pass(input logic [59:0] f, input int repulse,
                           output int done_edge, output int done_cnt);
      done_edge = -1;
      done_cnt  = 0;
      @(negedge clk);
      field_in = f;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         if (e == repulse) start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         if (e == 1) check_value("busy_after_start", 128'(busy), 128'd1);
         if (done) begin
            done_cnt++;
            if (done_edge < 0) done_edge = e;
         end
      end
   endtask

   task automatic check_pass(input string tag, input logic [59:0] f, input int repulse,
                             input int exp_edge, input logic [59:0] exp_field,
                             input logic [79:0] exp_border, input int exp_lines);
      int de;
      int dc;
      run_pass(f, repulse, de, dc);
      check_value({tag, "_done_edge"}, 128'(de), 128'(exp_edge));
      check_value({tag, "_done_count"}, 128'(dc), 128'd1);
      check_value({tag, "_field_out"}, 128'(field_out), 128'(exp_field));
      check_value({tag, "_border"}, 128'(border), 128'(exp_border));
      check_value({tag, "_lines"}, 128'(lines_cleared), 128'(exp_lines));
   endtask

   initial begin
      logic [59:0] f_one;
      logic [59:0] f_two;
      logic [59:0] f_full;
      int          dc;
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      start       = 1'b0;
      field_in    = '0;
      f_one  = full_row(5) | one_cell(3, 4);
      f_two  = full_row(2) | full_row(5) | one_cell(0, 4);
      f_full = '1;

      repeat (3) @(posedge clk);
      #1;
      check_value("rst_busy", 128'(busy), 128'd0);
      check_value("rst_done", 128'(done), 128'd0);
      check_value("rst_field_out", 128'(field_out), 128'd0);
      check_value("rst_lines", 128'(lines_cleared), 128'd0);
      check_value("rst_total", 128'(total_lines), 128'd0);
      check_value("rst_border", 128'(border), 128'(border_with(-1, 6)));
      @(negedge clk);
      rst = 1'b0;

      check_pass("empty", '0, -1, 16, '0, border_with(-1, 6), 0);
      check_pass("one_line_repulse", f_one, 3, 18, one_cell(3, 5), border_with(3, 5), 1);

      // Reset in the middle of a pass after a pass left non-reset results.
      @(negedge clk);
      field_in = f_two;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check_value("midrst_busy", 128'(busy), 128'd0);
      check_value("midrst_done", 128'(done), 128'd0);
      check_value("midrst_field_out", 128'(field_out), 128'd0);
      check_value("midrst_lines", 128'(lines_cleared), 128'd0);
      check_value("midrst_border", 128'(border), 128'(border_with(-1, 6)));
      @(negedge clk);
      rst = 1'b0;
      dc  = 0;
      for (int e = 0; e < 30; e++) begin
         @(posedge clk);
         #1;
         if (done) dc++;
      end
      check_value("midrst_no_done", 128'(dc), 128'd0);

      check_pass("one_line", f_one, -1, 18, one_cell(3, 5), border_with(3, 5), 1);
      check_pass("two_lines", f_two, -1, 20, one_cell(0, 5), border_with(0, 5), 2);
      check_pass("all_full", f_full, -1, 28, '0, border_with(-1, 6), 6);
`ifdef LINE_CLEAR_SCORE_EN
      check_value("total_lines", 128'(total_lines), 128'd9);
`else
      check_value("total_lines", 128'(total_lines), 128'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/line_clear.md
LINE_CLEAR -- requirements
Module: line_clear

Interface
REQ-001 Parameters SHALL be: MEM_WIDTH, default 10, field columns; MEM_HEIGHT, default 6, field rows; WIDTH, default 8, coordinate/count byte width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request; samples field_in.
REQ-005 field_in  input  MEM_WIDTH*MEM_HEIGHT  stored playfield; cell (i,j) at bit MEM_WIDTH*MEM_HEIGHT-1-(MEM_WIDTH*j+i); j=0 is the top row.
REQ-006 busy  output  1  high from the cycle after start is accepted until done.
REQ-007 done  output  1  one-cycle pulse; results valid.
REQ-008 field_out  output  MEM_WIDTH*MEM_HEIGHT  compacted field, same bit mapping as field_in.
REQ-009 border  output  MEM_WIDTH*WIDTH  per-column top-occupied row index; column 0 in the most-significant byte; MEM_HEIGHT if the column is empty.
REQ-010 lines_cleared  output  WIDTH  full rows removed in the last pass.
REQ-011 total_lines  output  16  running count of cleared lines (see Configuration).

Function
REQ-012 FSM states SHALL be IDLE, SCAN, SHIFT, BORDER, DONE.
REQ-013 IDLE: start=1 -> copy field_in to the internal field, row=MEM_HEIGHT-1, count=0, go to SCAN.
REQ-014 SCAN, one row per cycle: row full -> SHIFT; else row==0 -> BORDER with col=0; else row-1, stay in SCAN.
REQ-015 SHIFT, one cycle: rows 1..row take rows 0..row-1, row 0 cleared, count+1, return to SCAN with row unchanged (re-check).
REQ-016 BORDER, one column per cycle, col 0..MEM_WIDTH-1: write the smallest occupied j of column col (MEM_HEIGHT if none) into its border byte; after col MEM_WIDTH-1 -> DONE.
REQ-017 DONE: field_out, lines_cleared and border SHALL be updated together, done=1 for exactly one cycle, then -> IDLE.
REQ-018 With k cleared lines, done SHALL be high in the cycle following edge MEM_HEIGHT+2k+MEM_WIDTH, counting the edge that samples start as edge 0.
REQ-019 start while busy or in DONE SHALL be ignored.
REQ-020 field_out, border and lines_cleared SHALL hold their values between done pulses.
REQ-021 An all-full field SHALL clear MEM_HEIGHT lines and terminate.
REQ-022 Counters SHALL be sized for their full range; count SHALL never wrap at default parameters.

Reset
REQ-023 rst SHALL force IDLE immediately, including mid-pass, and discard the pass in progress.
REQ-024 Reset values: busy 0, done 0, field_out 0, lines_cleared 0, total_lines 0, every border byte MEM_HEIGHT.

Configuration
REQ-025 Macro LINE_CLEAR_SCORE_EN defined: total_lines SHALL add lines_cleared at each done and saturate at 16'hFFFF.
REQ-026 Macro LINE_CLEAR_SCORE_EN undefined: total_lines SHALL be constant 0 and no accumulator SHALL be instantiated.

Structure
REQ-027 MEM_WIDTH, MEM_HEIGHT and WIDTH defaults and the FSM state encoding SHALL live in the shared package tetris_pkg.
REQ-028 The per-column top-index priority encoder SHALL be one sub-module, column_height.
REQ-029 The internal field and output registers SHALL use the existing reset_register block.

Verification
REQ-030 Empty field, start -> done at edge 16, lines_cleared=0, field_out=0, all border bytes=6.
REQ-031 Bottom row full plus cell (3,4) -> lines_cleared=1, cell (3,5) only set, border col3=5, others 6, done at edge 18.
REQ-032 Rows 2 and 5 full, cell (0,4) set -> lines_cleared=2, cell (0,5) only set, done at edge 20.
REQ-033 All 60 cells set -> lines_cleared=6, field_out=0, done at edge 28.
REQ-034 start re-pulsed at edge 3 -> ignored, single done at the original time; rst at edge 5 -> immediate IDLE, all outputs at reset values, no done.
REQ-035 With LINE_CLEAR_SCORE_EN, passes clearing 1, 2 and 6 lines -> total_lines=9; without the macro -> total_lines=0.
